// File: rtl/minimac2_pkg.sv
// Shared types, constants and the byte-wise CRC-32 step for the minimac2 receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package minimac2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0]  NIB_PRE = 4'h5;
  localparam logic [3:0]  NIB_SFD = 4'hD;

  // Reflected CRC-32, one byte, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/minimac2_crc32.sv
// Running CRC-32 register over received bytes.
// Latency: register reflects a byte one cycle after en.
// Backpressure: none; accepts a byte every cycle en is high.
module minimac2_crc32
  import minimac2_pkg::*;
(
  input  logic        phy_rx_clk,
  input  logic        sys_rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // Clear wins over update so a new frame always starts from the init value.
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/minimac2_rx_framer.sv
// MII nibble receiver: strips preamble/SFD, assembles bytes, checks FCS/length, counts frames.
// Latency: a byte is emitted one byte-time after it completes (held so eof is known); eof one cycle after phy_dv falls.
// Backpressure: none; rx_valid is a single-cycle strobe the consumer must take.
module minimac2_rx_framer
  import minimac2_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        phy_rx_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  phy_rx_data,
  input  logic        phy_dv,
  input  logic        phy_rx_er,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic [15:0] rx_ok_count,
  output logic [15:0] rx_bad_count
);

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
  localparam logic [10:0] CNT_SAT   = 11'h7FF;

  state_t      state_q, state_d;
  logic        sfd_seen, byte_done, frame_end;
  logic        phase_q;
  logic [3:0]  low_nib_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q;
  logic        first_q;
  logic        er_q;
  logic [10:0] byte_cnt_q;
  logic [31:0] crc_val;
  logic [7:0]  cur_byte;
  logic        frame_bad;

  assign cur_byte  = {phy_rx_data, low_nib_q};
  assign frame_bad = (crc_val != CRC_RESIDUE) || er_q || phase_q ||
                     (byte_cnt_q < MIN_LEN_C) || (byte_cnt_q > MAX_LEN_C);

  minimac2_crc32 u_crc (
    .phy_rx_clk (phy_rx_clk),
    .sys_rst_n  (sys_rst_n),
    .clr        (sfd_seen),
    .en         (byte_done),
    .data       (cur_byte),
    .crc        (crc_val)
  );

  // State register.
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state plus the per-cycle strobes that steer the datapath.
  always_comb begin
    state_d   = state_q;
    sfd_seen  = 1'b0;
    byte_done = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (phy_dv) state_d = (phy_rx_data == NIB_PRE) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: begin
        if (!phy_dv) begin
          state_d = ST_IDLE;
        end else if (phy_rx_data == NIB_SFD) begin
          state_d  = ST_DATA;
          sfd_seen = 1'b1;
        end else if (phy_rx_data != NIB_PRE) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!phy_dv) begin
          state_d   = ST_IDLE;
          frame_end = 1'b1;
        end else if (phase_q) begin
          byte_done = 1'b1;
        end
      end
      ST_DROP: begin
        if (!phy_dv) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte assembly, one-byte hold and the registered output strobes.
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_q    <= 1'b0;
      low_nib_q  <= 4'h0;
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b0;
      er_q       <= 1'b0;
      byte_cnt_q <= 11'd0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
      if (sfd_seen) begin
        phase_q    <= 1'b0;
        hold_vld_q <= 1'b0;
        first_q    <= 1'b1;
        er_q       <= 1'b0;
        byte_cnt_q <= 11'd0;
      end
      if (state_q == ST_DATA && phy_dv) begin
        if (phy_rx_er) er_q <= 1'b1;
        if (!phase_q) begin
          low_nib_q <= phy_rx_data;
          phase_q   <= 1'b1;
        end else begin
          phase_q    <= 1'b0;
          hold_q     <= cur_byte;
          hold_vld_q <= 1'b1;
          if (byte_cnt_q != CNT_SAT) byte_cnt_q <= byte_cnt_q + 11'd1;
          if (hold_vld_q) begin
            rx_valid <= 1'b1;
            rx_data  <= hold_q;
            rx_sof   <= first_q;
            first_q  <= 1'b0;
          end
        end
      end
      if (frame_end) begin
        hold_vld_q <= 1'b0;
        if (hold_vld_q) begin
          rx_valid <= 1'b1;
          rx_data  <= hold_q;
          rx_sof   <= first_q;
          rx_eof   <= 1'b1;
          rx_err   <= frame_bad;
          first_q  <= 1'b0;
        end
      end
    end
  end

  // Frame counters: one of the two steps per ended frame; a frame with no byte counts as bad.
  always_ff @(posedge phy_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_ok_count  <= 16'd0;
      rx_bad_count <= 16'd0;
    end else if (frame_end) begin
      if (hold_vld_q && !frame_bad) rx_ok_count  <= rx_ok_count + 16'd1;
      else                          rx_bad_count <= rx_bad_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_minimac2_rx_framer.sv
// Directed and randomized frames against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_minimac2_rx_framer;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eof;
    logic       err;
  } rec_t;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic [3:0]  phy_rx_data;
  logic        phy_dv;
  logic        phy_rx_er;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_err;
  logic [15:0] rx_ok_count, rx_bad_count;

  int          total = 0;
  int          bad   = 0;
  int          stray = 0;
  logic [7:0]  frame_q[$];
  rec_t        got_q[$];
  rec_t        exp_q[$];
  logic [15:0] ok_m  = 16'd0;
  logic [15:0] bad_m = 16'd0;

  minimac2_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .phy_rx_clk   (clk),
    .sys_rst_n    (sys_rst_n),
    .phy_rx_data  (phy_rx_data),
    .phy_dv       (phy_dv),
    .phy_rx_er    (phy_rx_er),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .rx_err       (rx_err),
    .rx_ok_count  (rx_ok_count),
    .rx_bad_count (rx_bad_count)
  );

  always #5 clk = ~clk;

  // Capture every emitted byte; flag framing strobes that appear without rx_valid or eof.
  always @(negedge clk) begin
    if (rx_valid) got_q.push_back({rx_data, rx_sof, rx_eof, rx_err});
    else if (rx_sof || rx_eof || rx_err) stray++;
    if (rx_err && !rx_eof) stray++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ethernet FCS of the first n bytes of frame_q (final complement included).
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ frame_q[i][k]) == 1'b1) c = (c >> 1) ^ 32'hEDB8_8320;
        else                                c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input int plen, input bit seq);
    logic [31:0] f;
    frame_q.delete();
    for (int i = 0; i < plen; i++) frame_q.push_back(seq ? 8'(i) : 8'($urandom));
    f = fcs_of(plen);
    for (int i = 0; i < 4; i++) frame_q.push_back(f[8*i +: 8]);
  endtask

  // Reference: what the receiver should deliver for the frame in frame_q.
  task automatic expect_frame(input bit er, input bit extra);
    int   n = frame_q.size();
    bit   fcs_ok, errb;
    logic [31:0] tail;
    if (n == 0) begin
      bad_m++;
      return;
    end
    tail   = {frame_q[n-1], frame_q[n-2], frame_q[n-3], frame_q[n-4]};
    fcs_ok = (fcs_of(n - 4) == tail);
    errb   = er || extra || (n < 64) || (n > 1518) || !fcs_ok;
    for (int i = 0; i < n; i++)
      exp_q.push_back({frame_q[i], (i == 0), (i == n - 1), (i == n - 1) ? errb : 1'b0});
    if (errb) bad_m++;
    else      ok_m++;
  endtask

  task automatic drive(input logic dv, input logic [3:0] nib, input logic er);
    @(negedge clk);
    phy_dv      = dv;
    phy_rx_data = nib;
    phy_rx_er   = er;
  endtask

  task automatic send(input int pre_n, input bit er_mid, input bit extra, input int gap);
    int n = frame_q.size();
    for (int i = 0; i < pre_n; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, frame_q[i][3:0], er_mid && (i == n / 2));
      drive(1'b1, frame_q[i][7:4], 1'b0);
    end
    if (extra) drive(1'b1, 4'($urandom_range(15)), 1'b0);
    for (int i = 0; i < gap; i++) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic check_batch(input string tag);
    int mism = 0;
    int m;
    repeat (3) @(negedge clk);
    chk({tag, ":bytes"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (got_q[i] !== exp_q[i]) mism++;
    chk({tag, ":data"}, mism, 0);
    chk({tag, ":ok_count"}, rx_ok_count, ok_m);
    chk({tag, ":bad_count"}, rx_bad_count, bad_m);
    chk({tag, ":stray"}, stray, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int plen, mode;
    sys_rst_n   = 1'b0;
    phy_dv      = 1'b0;
    phy_rx_data = 4'h0;
    phy_rx_er   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst:valid", rx_valid, 0);
    chk("rst:sof", rx_sof, 0);
    chk("rst:eof", rx_eof, 0);
    chk("rst:err", rx_err, 0);
    chk("rst:data", rx_data, 0);
    chk("rst:ok", rx_ok_count, 0);
    chk("rst:bad", rx_bad_count, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reference 64-byte frame.
    build_frame(60, 1'b1);
    expect_frame(1'b0, 1'b0);
    send(15, 1'b0, 1'b0, 6);
    check_batch("good64");

    // Payload bit flip.
    build_frame(60, 1'b1);
    frame_q[10] = frame_q[10] ^ 8'h04;
    expect_frame(1'b0, 1'b0);
    send(15, 1'b0, 1'b0, 6);
    check_batch("bitflip");

    // Receive error mid-payload, then an odd trailing nibble.
    build_frame(60, 1'b1);
    expect_frame(1'b1, 1'b0);
    send(15, 1'b1, 1'b0, 6);
    check_batch("rx_er");
    build_frame(60, 1'b1);
    expect_frame(1'b0, 1'b1);
    send(15, 1'b0, 1'b1, 6);
    check_batch("odd_nib");

    // Length limits with valid FCS.
    build_frame(36, 1'b0);
    expect_frame(1'b0, 1'b0);
    send(15, 1'b0, 1'b0, 6);
    check_batch("runt40");
    build_frame(1515, 1'b0);
    expect_frame(1'b0, 1'b0);
    send(15, 1'b0, 1'b0, 6);
    check_batch("giant1519");
    build_frame(1514, 1'b0);
    expect_frame(1'b0, 1'b0);
    send(7, 1'b0, 1'b0, 6);
    check_batch("max1518");

    // Bad preamble: dropped silently, then a good frame.
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h3, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 4'($urandom_range(15)), 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    check_batch("bad_pre");
    build_frame(60, 1'b1);
    expect_frame(1'b0, 1'b0);
    send(15, 1'b0, 1'b0, 6);
    check_batch("after_bad_pre");

    // phy_dv drops right after SFD, and after a lone nibble.
    frame_q.delete();
    expect_frame(1'b0, 1'b0);
    send(3, 1'b0, 1'b0, 4);
    expect_frame(1'b0, 1'b1);
    send(3, 1'b0, 1'b1, 4);
    check_batch("empty");

    // Back-to-back: new frame starts in the cycle its predecessor's eof appears.
    build_frame(60, 1'b0);
    expect_frame(1'b0, 1'b0);
    send(2, 1'b0, 1'b0, 1);
    build_frame(61, 1'b0);
    expect_frame(1'b0, 1'b0);
    send(1, 1'b0, 1'b0, 6);
    check_batch("b2b");

    // Randomized frames.
    for (int r = 0; r < 10; r++) begin
      plen = $urandom_range(56, 110);
      mode = $urandom_range(3);
      build_frame(plen, 1'b0);
      if (mode == 1) frame_q[$urandom_range(plen - 1)] ^= 8'(1 << $urandom_range(7));
      expect_frame(mode == 2, mode == 3);
      send($urandom_range(1, 15), mode == 2, mode == 3, $urandom_range(1, 4));
    end
    check_batch("random");

    // Reset held for two cycles at byte 30 of a frame.
    build_frame(60, 1'b1);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, frame_q[i][3:0], 1'b0);
      drive(1'b1, frame_q[i][7:4], 1'b0);
    end
    @(negedge clk);
    sys_rst_n   = 1'b0;
    phy_rx_data = frame_q[30][3:0];
    @(negedge clk);
    phy_rx_data = frame_q[30][7:4];
    chk("midrst:valid", rx_valid, 0);
    chk("midrst:eof", rx_eof, 0);
    chk("midrst:data", rx_data, 0);
    chk("midrst:ok", rx_ok_count, 0);
    chk("midrst:bad", rx_bad_count, 0);
    got_q.delete();
    exp_q.delete();
    ok_m  = 16'd0;
    bad_m = 16'd0;
    @(negedge clk);
    sys_rst_n   = 1'b1;
    phy_rx_data = frame_q[31][3:0];
    drive(1'b1, frame_q[31][7:4], 1'b0);
    for (int i = 32; i < 64; i++) begin
      drive(1'b1, frame_q[i][3:0], 1'b0);
      drive(1'b1, frame_q[i][7:4], 1'b0);
    end
    drive(1'b0, 4'h0, 1'b0);
    check_batch("post_rst_drop");
    build_frame(60, 1'b1);
    expect_frame(1'b0, 1'b0);
    send(15, 1'b0, 1'b0, 6);
    check_batch("post_rst_good");
    chk("post_rst_ok1", rx_ok_count, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
